// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the write-back value, commits it to the
// 32x32 GPR array, serves two bypassed ID-stage read ports and counts retired instructions.
module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wb_reg_write_i,
  input  logic             wb_mem_to_reg_i,
  input  logic             wb_pc_to_reg_i,
  input  logic [4:0]       wb_write_addr_i,
  input  logic [31:0]      wb_alu_res_i,
  input  logic [31:0]      wb_mem_data_i,
  input  logic [31:0]      wb_pc_i,
  input  logic [31:0]      wb_ir_i,
  input  logic [4:0]       rs_addr_i,
  input  logic [4:0]       rt_addr_i,
  output logic [31:0]      rs_data_o,
  output logic [31:0]      rt_data_o,
  output logic [31:0]      wb_data_o,
  input  logic [4:0]       dbg_addr_i,
  output logic [31:0]      dbg_data_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int unsigned SpIdx = 29;

  logic [31:0]      regs_q [32];
  logic [CNT_W-1:0] retired_q;
  logic [31:0]      wb_data;
  logic             commit;

  // Link address has priority over load data, which has priority over the ALU result.
  always_comb begin
    wb_data = wb_alu_res_i;
    if (wb_pc_to_reg_i) begin
      wb_data = wb_pc_i + 32'd4;
    end else if (wb_mem_to_reg_i) begin
      wb_data = wb_mem_data_i;
    end
  end

  assign wb_data_o = wb_data;
  assign commit    = wb_reg_write_i && (wb_write_addr_i != 5'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == SpIdx) ? SP_INIT : 32'd0;
      end
    end else if (commit) begin
      regs_q[wb_write_addr_i] <= wb_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_q <= '0;
    end else if (wb_ir_i != 32'd0) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Same-cycle write-to-read bypass; r0 is forced to zero ahead of the bypass.
  always_comb begin
    rs_data_o = 32'd0;
    if (rs_addr_i != 5'd0) begin
      if (wb_reg_write_i && (wb_write_addr_i == rs_addr_i)) begin
        rs_data_o = wb_data;
      end else begin
        rs_data_o = regs_q[rs_addr_i];
      end
    end
  end

  always_comb begin
    rt_data_o = 32'd0;
    if (rt_addr_i != 5'd0) begin
      if (wb_reg_write_i && (wb_write_addr_i == rt_addr_i)) begin
        rt_data_o = wb_data;
      end else begin
        rt_data_o = regs_q[rt_addr_i];
      end
    end
  end

  assign dbg_data_o = (dbg_addr_i == 5'd0) ? 32'd0 : regs_q[dbg_addr_i];
  assign retired_o  = retired_q;

endmodule
